// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag-bit positions for alu_seq_acc.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  // Bit positions inside the packed flag vector.
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per clock, LSB first, 2*WIDTH product.
// Latency: start edge loads operands; done is high during the cycle whose edge performs step WIDTH.
// Backpressure: none; the parent only pulses start when it is idle and must latch product on done.
module alu_mul_seq #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH:0]     upper_d;
  logic [CW-1:0]      cnt_q;
  logic               run_q;

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    upper_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + ({1'b0, mcand_q} & {(WIDTH+1){prod_q[0]}});
    prod_d  = {upper_d, prod_q[WIDTH-1:1]};
  end

  // The final step's result is handed out combinationally so the parent latches it on the same edge.
  assign done    = run_q && (cnt_q == CW'(WIDTH-1));
  assign product = prod_d;

  // Operand load on start, then WIDTH iterations while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      mcand_q <= mcand;
      prod_q  <= {{WIDTH{1'b0}}, mplier};
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      prod_q <= prod_d;
      cnt_q  <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_acc.sv
// Registered ALU with accumulator operand, carry/zero/neg/ovf flags and iterative multiply.
// Latency: single-cycle ops valid one edge after accept; MUL valid WIDTH edges after accept.
// Backpressure: result and flags hold while out_ready=0; in_ready drops until the result is taken.
module alu_seq_acc
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_t                 state_q;
  logic [WIDTH-1:0]       res_q;
  logic [NUM_FLAGS-1:0]   flag_q;

  logic [WIDTH-1:0]       opa;
  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
  logic [WIDTH-1:0]       alu_res_d;
  logic [NUM_FLAGS-1:0]   alu_flag_d;
  logic [NUM_FLAGS-1:0]   mul_flag_d;
  logic                   alu_c;
  logic                   alu_v;

  logic                   accept;
  logic                   is_mul;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_prod;

  // The result register doubles as the accumulator, so acc_sel sees the latest result even unconsumed.
  assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL) && (MUL_EN != 0);
  assign mul_start = accept && is_mul;

  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_MUL_BUSY);
  assign result    = res_q;
  assign carry     = flag_q[FLAG_C];
  assign zero      = flag_q[FLAG_Z];
  assign neg       = flag_q[FLAG_N];
  assign ovf       = flag_q[FLAG_V];

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   (opa),
    .mplier  (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath; op 111 lands here only when the multiplier is disabled and yields all zeros.
  always_comb begin
    opa       = acc_sel ? res_q : a;
    sum       = {1'b0, opa} + {1'b0, b};
    diff      = {1'b0, opa} - {1'b0, b};
    alu_res_d = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_d = sum[WIDTH-1:0];
        alu_c     = sum[WIDTH];
        alu_v     = (opa[MSB] == b[MSB]) && (sum[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        alu_res_d = diff[WIDTH-1:0];
        alu_c     = diff[WIDTH];
        alu_v     = (opa[MSB] != b[MSB]) && (diff[MSB] != opa[MSB]);
      end
      OP_AND:  alu_res_d = opa & b;
      OP_OR:   alu_res_d = opa | b;
      OP_XOR:  alu_res_d = opa ^ b;
      OP_NOT:  alu_res_d = ~opa;
      OP_SHL: begin
        alu_res_d = {opa[WIDTH-2:0], 1'b0};
        alu_c     = opa[MSB];
      end
      default: alu_res_d = '0;
    endcase
    alu_flag_d         = '0;
    alu_flag_d[FLAG_C] = alu_c;
    alu_flag_d[FLAG_Z] = (alu_res_d == '0);
    alu_flag_d[FLAG_N] = alu_res_d[MSB];
    alu_flag_d[FLAG_V] = alu_v;
    if (op == OP_MUL) alu_flag_d = '0;
  end

  // Multiply flags: carry reports any bit lost from the upper half of the product.
  always_comb begin
    mul_flag_d         = '0;
    mul_flag_d[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flag_d[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flag_d[FLAG_N] = mul_prod[MSB];
  end

  // Control FSM with result/flag registers; HOLD can take the next op on the same edge it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flag_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL_BUSY;
            end else begin
              state_q <= ST_HOLD;
              res_q   <= alu_res_d;
              flag_q  <= alu_flag_d;
            end
          end else if ((state_q == ST_HOLD) && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            state_q <= ST_HOLD;
            res_q   <= mul_prod[WIDTH-1:0];
            flag_q  <= mul_flag_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Self-checking bench for alu_seq_acc: directed test-plan steps followed by randomized ops.
// Expected values come from an integer-arithmetic reference model of the operation rules.
// Backpressure is exercised with held out_ready=0 windows and back-to-back accepts.
module tb_alu_seq_acc;

  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          acc_sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          zero;
  logic          neg;
  logic          ovf;
  logic          busy;

  int            total = 0;
  int            bad   = 0;

  longint        mdl_acc;
  longint        exp_res;
  logic          exp_c, exp_z, exp_n, exp_v;

  always #5 clk = ~clk;

  alu_seq_acc #(
    .WIDTH  (W),
    .MUL_EN (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_sel   (acc_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic, signed overflow via range test.
  task automatic model(input logic [2:0] o, input longint av, input longint bv);
    longint m, half, r, sa, sb, s;
    m    = longint'(1) << W;
    half = m / 2;
    sa   = (av >= half) ? av - m : av;
    sb   = (bv >= half) ? bv - m : bv;
    exp_c = 1'b0;
    exp_v = 1'b0;
    case (o)
      3'd0: begin r = av + bv; exp_c = (r >= m); s = sa + sb; exp_v = (s >= half) || (s < -half); end
      3'd1: begin r = av - bv + m; exp_c = (av < bv); s = sa - sb; exp_v = (s >= half) || (s < -half); end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: r = (m - 1) - av;
      3'd6: begin r = 2 * av; exp_c = (av >= half); end
      default: begin r = av * bv; exp_c = (r >= m); end
    endcase
    exp_res = r % m;
    exp_z   = (exp_res == 0);
    exp_n   = (exp_res >= half);
    mdl_acc = exp_res;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_c"}, carry, exp_c);
    chk({tag, "_z"}, zero, exp_z);
    chk({tag, "_n"}, neg, exp_n);
    chk({tag, "_v"}, ovf, exp_v);
  endtask

  // Present an op, wait (bounded) for in_ready, let it be accepted on the next edge.
  task automatic accept(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic s);
    longint opa;
    int n;
    op = o; a = av; b = bv; acc_sel = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    chk("accept_ready", in_ready, 1);
    opa = s ? mdl_acc : longint'(av);
    model(o, opa, longint'(bv));
    tick;
    in_valid = 1'b0;
  endtask

  task automatic consume;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("consume_vld", out_valid, 0);
  endtask

  initial begin
    int n;
    int stall;
    logic [2:0] ro;
    logic [W-1:0] ra, rb, held;
    logic rs;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_sel = 1'b0; out_ready = 1'b0;
    mdl_acc = 0;
    tick;
    tick;
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", result, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_flags", {carry, zero, neg, ovf}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", in_ready, 1);

    // 1: back-to-back single-cycle ops
    out_ready = 1'b1;
    accept(3'd0, 5, 3, 0); chk_out("t1_add"); chk("t1_add_lit", result, 8);
    accept(3'd1, 5, 3, 0); chk_out("t1_sub"); chk("t1_sub_lit", result, 2);
    accept(3'd5, 5, 0, 0); chk_out("t1_not"); chk("t1_not_lit", result, 26);
    consume;

    // 2: borrow, carry, signed overflow
    accept(3'd1, 3, 5, 0);  chk_out("t2_sub"); chk("t2_sub_lit", {result, carry, neg, ovf}, {5'd30, 3'b110});
    accept(3'd0, 20, 15, 0); chk_out("t2_addc"); chk("t2_addc_lit", {result, carry}, {5'd3, 1'b1});
    accept(3'd0, 7, 9, 0);  chk_out("t2_addv"); chk("t2_addv_lit", {result, ovf, neg}, {5'd16, 2'b11});
    consume;

    // 3: multiply, busy for exactly W cycles
    accept(3'd7, 6, 7, 0);
    for (int k = 0; k < W; k++) begin
      chk("t3_busy", busy, 1);
      chk("t3_rdy", in_ready, 0);
      chk("t3_novld", out_valid, 0);
      tick;
    end
    chk("t3_busy_end", busy, 0);
    chk_out("t3_mul"); chk("t3_mul_lit", {result, carry}, {5'd10, 1'b1});
    consume;
    accept(3'd7, 3, 4, 0);
    n = 0;
    while (!out_valid && n < W + 3) begin tick; n++; end
    chk_out("t3_mul2"); chk("t3_mul2_lit", {result, carry}, {5'd12, 1'b0});
    consume;

    // 4: accumulator chain, a forced to 31 on acc_sel ops
    accept(3'd0, 4, 1, 0);  chk_out("t4_a"); chk("t4_a_lit", result, 5);
    accept(3'd0, 31, 2, 1); chk_out("t4_b"); chk("t4_b_lit", result, 7);
    accept(3'd6, 31, 0, 1); chk_out("t4_c"); chk("t4_c_lit", result, 14);
    consume;

    // 5: backpressure then accept on the consuming edge
    out_ready = 1'b0;
    accept(3'd0, 1, 1, 0); chk_out("t5_add");
    op = 3'd4; a = 6; b = 3; acc_sel = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_hold_res", result, 2);
      chk("t5_hold_vld", out_valid, 1);
      chk("t5_hold_rdy", in_ready, 0);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("t5_rdy", in_ready, 1);
    model(3'd4, 6, 3);
    tick;
    in_valid = 1'b0;
    chk_out("t5_xor"); chk("t5_xor_lit", result, 5);
    consume;

    // 6: reset in the third busy cycle aborts the multiply
    accept(3'd7, 6, 7, 0);
    tick;
    tick;
    chk("t6_busy3", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    mdl_acc = 0;
    chk("t6_vld", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_res", result, 0);
    chk("t6_flags", {carry, zero, neg, ovf}, 0);
    chk("t6_rdy", in_ready, 1);
    for (int k = 0; k < W + 2; k++) begin
      tick;
      chk("t6_nopulse", out_valid, 0);
    end
    accept(3'd0, 9, 0, 1); chk_out("t6_acc0"); chk("t6_acc0_lit", result, 0);
    accept(3'd0, 2, 2, 0); chk_out("t6_add"); chk("t6_add_lit", result, 4);
    consume;

    // Randomized ops with random stalls
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      accept(ro, ra, rb, rs);
      n = 0;
      while (!out_valid && n < W + 3) begin tick; n++; end
      chk_out("rnd");
      out_ready = 1'b0;
      held = result;
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        tick;
        chk("rnd_hold", result, exp_res);
        chk("rnd_hold_rdy", in_ready, 0);
      end
      if (held != result) chk("rnd_stable", result, held);
      consume;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_acc.md
Name: alu_seq_acc

Overview:
Parametrised, registered successor to the 5-bit 8-operation ALU. It adds an accumulator operand source and a registered flag set (carry, zero, negative, overflow). It has valid/ready handshakes on input and output, and an iterative shift-add multiply that takes WIDTH cycles. It sits between the vending controller's datapath (price/credit/change arithmetic) and its result consumers.

Parameters:
WIDTH, 5, operand/result width in bits (legal 2..32)
MUL_EN, 1, 1 = op 111 is a multi-cycle multiply; 0 = op 111 completes in one cycle with result 0 and all flags 0

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A (ignored when acc_sel=1)
b  input  WIDTH  operand B
op  input  3  operation code
acc_sel  input  1  1 = use accumulator as operand A
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry  output  1  carry/borrow flag
zero  output  1  result == 0
neg  output  1  result MSB
ovf  output  1  signed overflow
busy  output  1  multiply in progress

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset values: all outputs 0, accumulator 0, state IDLE. in_ready rises in the first cycle after rst deasserts.
- Reset during MUL_BUSY or HOLD aborts the operation and discards the result, with no out_valid pulse.
- Transfer occurs on a rising edge when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This allows back-to-back single-cycle ops at one per clock.
- Operand A = acc_sel ? acc : a, sampled on the accepting edge. Later changes on a, b, op or acc_sel have no effect.
- Ops (arithmetic is modulo 2^WIDTH):
  - 000 ADD: carry = bit WIDTH of a+b.
  - 001 SUB: carry = borrow, i.e. 1 when A<B unsigned.
  - 010 AND, 011 OR, 100 XOR: carry 0.
  - 101 NOT A: carry 0.
  - 110 SHL A by 1: carry = A[MSB].
  - 111 MUL: result = low WIDTH bits of A*B; carry = 1 if the high WIDTH bits are nonzero.
- ovf is signed two's-complement overflow for ADD and SUB only, and 0 for all other ops. zero = (result==0). neg = result[WIDTH-1].
- States:
  - IDLE: on accept of a non-MUL op, go to HOLD. On accept of MUL with MUL_EN=1, go to MUL_BUSY.
  - MUL_BUSY: consumes one multiplier bit per edge, LSB first. After the WIDTH-th edge, go to HOLD. busy=1 only in this state. in_ready=0.
  - HOLD: out_valid=1. If out_ready and a new accept occurs, take the next op directly. If out_ready and no accept, go to IDLE. If out_ready=0, result and flags stay stable.
- Latency:
  - Single-cycle op accepted on edge E0 gives out_valid=1 after E0.
  - MUL accepted on E0 gives out_valid=1 after edge E0+WIDTH.
- The accumulator and the flag registers load at the same edge out_valid rises. acc_sel on the next op therefore sees the previous result even if it has not yet been consumed.
- in_valid during MUL_BUSY is ignored, since in_ready=0. The source must hold its request until it is accepted.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - state encoding ST_IDLE, ST_MUL_BUSY, ST_HOLD;
  - a flag-bit index constant.
- One sub-module, alu_mul_seq: a shift-add multiplier with start/done, WIDTH-cycle latency and a 2*WIDTH product. The top block keeps combinational single-cycle ops, the FSM, the accumulator and the flag registers.

Test Plan:
1. WIDTH=5, out_ready=1. ADD a=5 b=3, then SUB 5-3, then NOT 5 on consecutive cycles -> results 8, 2, 26 on three consecutive out_valid cycles, each one cycle after accept; zero=0 throughout.
2. SUB a=3 b=5 -> result 30, carry=1, neg=1, ovf=0. ADD a=20 b=15 -> result 3, carry=1. ADD a=7 b=9 -> result 16, ovf=1, neg=1.
3. MUL a=6 b=7 -> busy=1 for 5 cycles, in_ready=0 over the same cycles; then result 10, carry=1. MUL a=3 b=4 -> result 12, carry=0.
4. Accumulator chain: ADD 4+1, then ADD acc_sel=1 b=2, then SHL acc_sel=1 -> results 5, 7, 14; a is driven to 31 throughout to prove it is ignored.
5. Backpressure: out_ready=0 for 4 cycles after ADD 1+1 -> result 2 held stable, in_ready=0; out_ready=1 with a new in_valid -> next op accepted on the same edge.
6. Assert rst for one cycle mid-MUL (third busy cycle) -> all outputs 0 next cycle, no out_valid, acc=0; a fresh ADD 2+2 afterwards gives 4.
